// File: rtl/imem_dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_dmem_arbiter_if
//  Brief    : Requester and memory bus bundle shared by the IF/D arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface imem_dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [3:0]            d_be;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Pipeline and memory side
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imem_dmem_arbiter
//  Brief    : Single-port memory arbiter, data-priority with IF starvation
//             guard. Optional fetch-stall counter: define ARB_STALL_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_dmem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    imem_dmem_arbiter_if.slave  bus
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [31:0]         if_stall_cnt
`endif
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    logic                  r_resp_if;
    logic                  r_resp_d;
    logic                  r_resp_st;
    logic [3:0]            r_starve_cnt;

    logic                  w_starved;
    logic                  w_if_gnt;
    logic                  w_d_gnt;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [3:0]            w_mem_we;

    // IF only wins a conflict once it has been denied STARVE_LIMIT times in a row
    assign w_starved = (r_starve_cnt == c_starve_limit);
    assign w_if_gnt  = ~rst & bus.if_req & (~bus.d_req | w_starved);
    assign w_d_gnt   = ~rst & bus.d_req  & ~(bus.if_req & w_starved);

    always_comb begin
        w_mem_addr  = bus.if_addr;
        w_mem_wdata = '0;
        w_mem_we    = 4'b0000;
        if (w_d_gnt) begin
            w_mem_addr  = bus.d_addr;
            w_mem_wdata = bus.d_wdata;
            if (bus.d_we) begin
                w_mem_we = bus.d_be;
            end
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.mem_en    = w_if_gnt | w_d_gnt;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_if    <= 1'b0;
            r_resp_d     <= 1'b0;
            r_resp_st    <= 1'b0;
            r_starve_cnt <= 4'd0;
        end else begin
            r_resp_if <= w_if_gnt;
            r_resp_d  <= w_d_gnt;
            r_resp_st <= w_d_gnt & bus.d_we;
            if (~bus.if_req | w_if_gnt) begin
                r_starve_cnt <= 4'd0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    // Memory read data lands one cycle after the grant; stores return zero
    assign bus.if_rvalid = r_resp_if;
    assign bus.d_rvalid  = r_resp_d;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = r_resp_st ? '0 : bus.mem_rdata;

`ifdef ARB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (bus.if_req & ~w_if_gnt & ~(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign if_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_dmem_arbiter
//  Brief    : Scoreboard bench for imem_dmem_arbiter with a behavioural
//             memory and arbitration reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef ARB_STALL_CNT_EN
    logic [31:0] if_stall_cnt;
`endif

    imem_dmem_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ARB_STALL_CNT_EN
        ,
        .if_stall_cnt(if_stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Memory instance seen by the DUT, and the bench's own view of its contents
    logic [31:0] ram     [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            logic [31:0] w;
            int unsigned k;
            k = bus.mem_addr >> 2;
            w = ram.exists(k) ? ram[k] : 32'd0;
            bus.mem_rdata <= w;
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            ram[k] = w;
        end
    end

    typedef struct packed {
        logic        rst_on;
        logic        win;
        logic        ig;
        logic        dg;
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        irv;
        logic        drv;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] if_resp_q[$];
    logic [31:0] d_resp_q[$];

    // Requester state (what the pipeline is currently asking for)
    logic        ir = 1'b0;
    logic [31:0] ia = 32'd0;
    logic        dr = 1'b0;
    logic        dwe = 1'b0;
    logic [3:0]  dbe = 4'd0;
    logic [31:0] da = 32'd0;
    logic [31:0] dwd = 32'd0;
    int          if_wait = 0;
    logic        prev_ig = 1'b0;
    logic        prev_dg = 1'b0;
    logic        win = 1'b0;

    int win_if = 0;
    int win_d = 0;
    int win_both = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'd0;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        ram[a >> 2]     = v;
        ref_mem[a >> 2] = v;
    endtask

    task automatic set_if(input logic [31:0] a);
        ir = 1'b1;
        ia = a;
    endtask

    task automatic set_d(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
        dr  = 1'b1;
        dwe = we;
        dbe = be;
        da  = a;
        dwd = wd;
    endtask

    // One bus cycle: drive inputs, predict grants/responses from the rules
    task automatic drive_cycle(input logic do_rst);
        exp_t e;
        logic g_if, g_d;
        logic [31:0] tmp;
        @(posedge clk);
        #1;
        rst           = do_rst;
        bus.if_req    = ir;
        bus.if_addr   = ia;
        bus.d_req     = dr;
        bus.d_we      = dwe;
        bus.d_be      = dbe;
        bus.d_addr    = da;
        bus.d_wdata   = dwd;
        e             = '0;
        e.rst_on      = do_rst;
        e.win         = win;
        if (do_rst) begin
            g_if = 1'b0;
            g_d  = 1'b0;
            if_resp_q.delete();
            d_resp_q.delete();
            if_wait = 0;
        end else begin
            if (!ir) if_wait = 0;
            g_d   = dr && !(ir && if_wait >= STARVE_LIMIT);
            g_if  = ir && !g_d;
            e.irv = prev_ig;
            e.drv = prev_dg;
        end
        e.ig    = g_if;
        e.dg    = g_d;
        e.en    = g_if | g_d;
        e.we    = (g_d && dwe) ? dbe : 4'd0;
        e.addr  = g_d ? da : ia;
        e.wdata = dwd;
        if (g_if) begin
            if_resp_q.push_back(ref_rd(ia));
            ir      = 1'b0;
            if_wait = 0;
        end else if (ir && !do_rst) begin
            if_wait++;
        end
        if (g_d) begin
            if (dwe) begin
                tmp = ref_rd(da);
                for (int b = 0; b < 4; b++)
                    if (dbe[b]) tmp[8*b +: 8] = dwd[8*b +: 8];
                ref_mem[da >> 2] = tmp;
                d_resp_q.push_back(32'd0);
            end else begin
                d_resp_q.push_back(ref_rd(da));
            end
            dr = 1'b0;
        end
        prev_ig = g_if;
        prev_dg = g_d;
        exp_q.push_back(e);
    endtask

    // Reset raised mid-cycle, before the edge that would launch the response
    task automatic late_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        if_resp_q.delete();
        d_resp_q.delete();
        prev_ig = 1'b0;
        prev_dg = 1'b0;
        if_wait = 0;
    endtask

    exp_t e_m;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_m = exp_q.pop_front();
            chk("if_gnt",    32'(bus.if_gnt),    32'(e_m.ig));
            chk("d_gnt",     32'(bus.d_gnt),     32'(e_m.dg));
            chk("gnt_onehot", 32'(bus.if_gnt & bus.d_gnt), 32'd0);
            chk("mem_en",    32'(bus.mem_en),    32'(e_m.en));
            chk("mem_we",    32'(bus.mem_we),    32'(e_m.we));
            chk("mem_addr",  bus.mem_addr,       e_m.addr);
            if (e_m.dg) chk("mem_wdata", bus.mem_wdata, e_m.wdata);
            chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_m.irv));
            chk("d_rvalid",  32'(bus.d_rvalid),  32'(e_m.drv));
            if (e_m.win) begin
                if (bus.if_gnt) win_if++;
                if (bus.d_gnt) win_d++;
                if (bus.if_gnt && bus.d_gnt) win_both++;
            end
        end
        if (bus.if_rvalid) begin
            if (if_resp_q.size() == 0) chk("if_rvalid_spurious", 32'd1, 32'd0);
            else chk("if_rdata", bus.if_rdata, if_resp_q.pop_front());
        end
        if (bus.d_rvalid) begin
            if (d_resp_q.size() == 0) chk("d_rvalid_spurious", 32'd1, 32'd0);
            else chk("d_rdata", bus.d_rdata, d_resp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_be    = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        preload(32'h0, 32'h0000_0013);
        preload(32'h4, 32'h0000_0013);
        preload(32'h8, 32'h0000_0013);
        preload(32'hC, 32'h0000_0093);
        preload(32'h100, 32'hDEAD_BEEF);
        preload(32'h200, 32'h1122_3344);
        for (int i = 0; i < 16; i++) preload(32'h400 + 32'(i * 4), $urandom);

        drive_cycle(1'b1);
        drive_cycle(1'b1);
`ifdef ARB_STALL_CNT_EN
        #1;
        chk("stall_cnt_reset", if_stall_cnt, 32'd0);
`endif

        // Fetch-only stream
        for (int i = 0; i < 3; i++) begin
            set_if(32'(i * 4));
            drive_cycle(1'b0);
        end
        drive_cycle(1'b0);
        drive_cycle(1'b0);

        // Conflict: data wins, fetch follows
        set_if(32'hC);
        set_d(1'b0, 4'h0, 32'h100, 32'h0);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        drive_cycle(1'b0);

        // Partial store then read-back
        set_d(1'b1, 4'b0011, 32'h200, 32'hAABB_CCDD);
        drive_cycle(1'b0);
        set_d(1'b0, 4'h0, 32'h200, 32'h0);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        drive_cycle(1'b0);

        // Reset while a load is in flight
        set_d(1'b0, 4'h0, 32'h100, 32'h0);
        drive_cycle(1'b0);
        late_reset();
`ifdef ARB_STALL_CNT_EN
        #1;
        chk("stall_cnt_midreset", if_stall_cnt, 32'd0);
`endif
        drive_cycle(1'b1);
        drive_cycle(1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0);

        // Starvation window: both requesters held for 12 cycles
        win = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (!ir) set_if(32'h400 + 32'($urandom_range(0, 15) << 2));
            if (!dr) set_d(1'b0, 4'h0, 32'h400 + 32'($urandom_range(0, 15) << 2), 32'h0);
            drive_cycle(1'b0);
        end
        win = 1'b0;
        drive_cycle(1'b0);
        @(negedge clk);
        #1;
        chk("starve_if_grants", 32'(win_if), 32'd2);
        chk("starve_d_grants", 32'(win_d), 32'd10);
        chk("starve_both", 32'(win_both), 32'd0);
`ifdef ARB_STALL_CNT_EN
        chk("stall_cnt_12", if_stall_cnt, 32'd10);
`endif

        // Randomised traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            if (!ir && $urandom_range(0, 2) != 0)
                set_if(32'h400 + 32'($urandom_range(0, 15) << 2));
            if (!dr && $urandom_range(0, 1) != 0)
                set_d(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      32'h400 + 32'($urandom_range(0, 15) << 2), $urandom);
            drive_cycle($urandom_range(0, 99) == 0);
        end

        ir = 1'b0;
        dr = 1'b0;
        for (int i = 0; i < 3; i++) drive_cycle(1'b0);
        @(negedge clk);
        #1;
        chk("if_resp_left", 32'(if_resp_q.size()), 32'd0);
        chk("d_resp_left", 32'(d_resp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
